// File: rtl/d_input_debouncer.sv
// d_input_debouncer: synchronises and debounces a bouncy raw input before it reaches d_flipflop.d
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   d_raw   - asynchronous raw input (switch/pin)
//   d_clean - debounced registered level
//   busy    - high while a candidate level is being qualified
//   rise    - one-cycle pulse on d_clean 0->1 (DEBOUNCE_EDGE_OUT_EN only)
//   fall    - one-cycle pulse on d_clean 1->0 (DEBOUNCE_EDGE_OUT_EN only)
// Build option: define DEBOUNCE_EDGE_OUT_EN to add the rise/fall ports and their flops.
module d_input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_raw,
  output logic d_clean,
  output logic busy
`ifdef DEBOUNCE_EDGE_OUT_EN
  ,
  output logic rise,
  output logic fall
`endif
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  typedef enum logic [1:0] {
    S_LOW      = 2'b00,
    S_CHK_HIGH = 2'b01,
    S_HIGH     = 2'b11,
    S_CHK_LOW  = 2'b10
  } state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic d_sync, clean_nx, last;
  assign d_sync = sync[SYNC_STAGES-1];
  assign last = cnt == CNT_W'(STABLE_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], d_raw};
  // The counter only advances in CHK states and leaves them on reaching the
  // final count, so it saturates at STABLE_CYCLES-1 without explicit clamping.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clean_nx = d_clean;
    case (state)
      S_LOW: begin
        state_nx = d_sync ? S_CHK_HIGH : S_LOW;
        cnt_nx   = d_sync ? CNT_W'(1) : '0;
      end
      S_CHK_HIGH:
        if (!d_sync) begin
          state_nx = S_LOW;
          cnt_nx   = '0;
        end else if (last) begin
          state_nx = S_HIGH;
          cnt_nx   = '0;
          clean_nx = 1'b1;
        end else cnt_nx = cnt + 1'b1;
      S_HIGH: begin
        state_nx = d_sync ? S_HIGH : S_CHK_LOW;
        cnt_nx   = d_sync ? '0 : CNT_W'(1);
      end
      default:
        if (d_sync) begin
          state_nx = S_HIGH;
          cnt_nx   = '0;
        end else if (last) begin
          state_nx = S_LOW;
          cnt_nx   = '0;
          clean_nx = 1'b0;
        end else cnt_nx = cnt + 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= S_LOW;
      cnt     <= '0;
      d_clean <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      d_clean <= clean_nx;
      busy    <= state_nx == S_CHK_HIGH || state_nx == S_CHK_LOW;
    end
`ifdef DEBOUNCE_EDGE_OUT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= clean_nx & ~d_clean;
      fall <= ~clean_nx & d_clean;
    end
`endif
endmodule

// File: tb/tb_d_input_debouncer.sv
// tb_d_input_debouncer: table-driven and directed checks of d_input_debouncer at default parameters
module tb_d_input_debouncer;
  logic clk = 1'b0, rst_n = 1'b0, d_raw = 1'b1;
  logic d_clean, busy, rise, fall;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic d;
    logic clean;
    logic busy;
    logic rise;
    logic fall;
  } vec_t;
  vec_t tv[48];
  always #5 clk = ~clk;
  d_input_debouncer dut (
    .clk(clk),
    .rst_n(rst_n),
    .d_raw(d_raw),
    .d_clean(d_clean),
    .busy(busy)
`ifdef DEBOUNCE_EDGE_OUT_EN
    ,
    .rise(rise),
    .fall(fall)
`endif
  );
`ifndef DEBOUNCE_EDGE_OUT_EN
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic c, input logic b, input logic r, input logic f);
    chk({tag, " d_clean"}, d_clean, c);
    chk({tag, " busy"}, busy, b);
`ifdef DEBOUNCE_EDGE_OUT_EN
    chk({tag, " rise"}, rise, r);
    chk({tag, " fall"}, fall, f);
`endif
  endtask
  initial begin
    tv = '{
      5'b0_0000, 5'b1_0000, 5'b1_0000, 5'b1_0100, 5'b1_0100, 5'b1_0100, 5'b1_1010, 5'b1_1000,
      5'b0_1000, 5'b0_1000, 5'b0_1100, 5'b1_1100, 5'b1_1100, 5'b1_1000, 5'b1_1000,
      5'b0_1000, 5'b1_1000, 5'b0_1100, 5'b1_1000, 5'b0_1100, 5'b1_1000, 5'b0_1100, 5'b1_1000,
      5'b0_1100, 5'b0_1000, 5'b0_1100, 5'b0_1100, 5'b0_1100, 5'b0_0001, 5'b0_0000,
      5'b1_0000, 5'b1_0000, 5'b1_0100, 5'b1_0100, 5'b0_0100, 5'b0_1010,
      5'b0_1100, 5'b0_1100, 5'b0_1100, 5'b0_0001, 5'b0_0000,
      5'b1_0000, 5'b1_0000, 5'b1_0100, 5'b0_0100, 5'b0_0100, 5'b0_0000, 5'b0_0000
    };
    #1;
    chk("reset d_clean", d_clean, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset rise", rise, 1'b0);
    chk("reset fall", fall, 1'b0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 48; i++) begin
      d_raw = tv[i].d;
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), tv[i].clean, tv[i].busy, tv[i].rise, tv[i].fall);
      checks++;
      if (rise && fall) begin
        errors++;
        $display("FAIL row%0d rise_fall_overlap: got 11 expected not both", i);
      end
    end
    d_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst busy before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all("midrst during", 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("midrst edge%0d", e), e >= 6, e >= 3 && e <= 5, e == 6, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
